// File: rtl/decoration_sequencer_if.sv
// Program/status interface of the decoration sequencer.
// The master side (host or testbench) drives run enable, program writes and
// dwell; the slave side (the sequencer) drives the decoded actuator outputs.
interface decoration_sequencer_if #(
  parameter int NUM_CH  = 4,
  parameter int DWELL_W = 8
);
  localparam int AW = $clog2(NUM_CH);

  logic               on;
  logic               prog_we;
  logic [AW-1:0]      prog_addr;
  logic [3:0]         prog_data;
  logic [DWELL_W-1:0] dwell;

  logic [3:0]         opcode;
  logic [AW-1:0]      step;
  logic               running;
  logic [1:0]         color;
  logic               sound_stb;
  logic [1:0]         sound_id;
  logic [2:0]         effect;
  logic               wrap;
  logic               err;

  modport master (
    output on, prog_we, prog_addr, prog_data, dwell,
    input  opcode, step, running, color, sound_stb, sound_id, effect, wrap, err
  );

  modport slave (
    input  on, prog_we, prog_addr, prog_data, dwell,
    output opcode, step, running, color, sound_stb, sound_id, effect, wrap, err
  );
endinterface

// File: rtl/decoration_sequencer.sv
// Decoration opcode sequencer: steps through a writable program of NUM_CH
// 4-bit opcodes, holding each step for dwell+1 cycles, and decodes every
// step into latched colour, one-cycle sound strobes and held effects.
// Optional build macro SEQ_ONESHOT_EN: play the program once and park in
// DONE instead of wrapping back to step 0.
module decoration_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int DWELL_W = 8,
  parameter int OP_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  decoration_sequencer_if.slave  bus
);
  localparam int            AW       = $clog2(NUM_CH);
  localparam logic [AW-1:0] LAST     = AW'(NUM_CH - 1);
  localparam logic [OP_W-1:0] OP_RESET = OP_W'(1);

`ifdef SEQ_ONESHOT_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_e;
`endif

  state_e             state_q, state_d;
  logic [OP_W-1:0]    mem_q [NUM_CH];
  logic [AW-1:0]      step_q, step_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [OP_W-1:0]    opcode_q, opcode_d;
  logic [1:0]         color_q, color_d;
  logic [2:0]         effect_q, effect_d;
  logic               sound_stb_q, sound_stb_d;
  logic [1:0]         sound_id_q, sound_id_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;

  logic               enter;
  logic [AW-1:0]      entry_step;
  logic [OP_W-1:0]    entry_op;

  // Next-state logic: state transitions, dwell countdown and step-entry decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d     = state_q;
    step_d      = step_q;
    dwell_cnt_d = dwell_cnt_q;
    opcode_d    = opcode_q;
    color_d     = color_q;
    effect_d    = effect_q;
    sound_stb_d = 1'b0;
    sound_id_d  = 2'b00;
    wrap_d      = 1'b0;
    err_d       = err_q;
    enter       = 1'b0;
    entry_step  = '0;
    entry_op    = '0;

    case (state_q)
      S_IDLE: begin
        // Old slot-0 contents decide the start; a same-cycle write lands later.
        if (bus.on && (mem_q[0] != '0)) begin
          state_d    = S_RUN;
          enter      = 1'b1;
          entry_step = '0;
        end
      end
      S_RUN: begin
        if (!bus.on) begin
          state_d     = S_IDLE;
          step_d      = '0;
          dwell_cnt_d = '0;
          opcode_d    = '0;
          color_d     = 2'b00;
          effect_d    = 3'b000;
        end else if (opcode_q == OP_RESET) begin
          // RESET returns to slot 0 immediately, without a wrap pulse.
          enter      = 1'b1;
          entry_step = '0;
        end else if (dwell_cnt_q == '0) begin
          if (step_q == LAST) begin
`ifdef SEQ_ONESHOT_EN
            state_d  = S_DONE;
            step_d   = '0;
            opcode_d = '0;
            effect_d = 3'b000;
`else
            enter      = 1'b1;
            entry_step = '0;
            wrap_d     = 1'b1;
`endif
          end else begin
            enter      = 1'b1;
            entry_step = step_q + 1'b1;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - 1'b1;
        end
      end
`ifdef SEQ_ONESHOT_EN
      S_DONE: begin
        if (!bus.on) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Step entry: latch the opcode, reload dwell and perform the class action.
    if (enter) begin
      entry_op    = mem_q[entry_step];
      step_d      = entry_step;
      opcode_d    = entry_op;
      dwell_cnt_d = bus.dwell;
      effect_d    = 3'b000;
      case (entry_op[3:2])
        2'b00: begin
          if (entry_op[1:0] == 2'b01) color_d = 2'b00;
          else if (entry_op[1:0] != 2'b00) err_d = 1'b1;
        end
        2'b01: begin
          if (entry_op[1:0] == 2'b11) err_d = 1'b1;
          else color_d = entry_op[1:0] + 2'd1;
        end
        2'b10: begin
          if (entry_op[1:0] == 2'b11) err_d = 1'b1;
          else begin
            sound_stb_d = 1'b1;
            sound_id_d  = entry_op[1:0];
          end
        end
        default: begin
          if (entry_op[1:0] == 2'b11) err_d = 1'b1;
          else effect_d = 3'b001 << entry_op[1:0];
        end
      endcase
    end
  end

  // State and output registers plus program memory, all cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the program store is a small register file, so clearing it in
      // reset is cheap and makes an empty program the defined start-up state.
      for (int i = 0; i < NUM_CH; i++) mem_q[i] <= '0;
      state_q     <= S_IDLE;
      step_q      <= '0;
      dwell_cnt_q <= '0;
      opcode_q    <= '0;
      color_q     <= 2'b00;
      effect_q    <= 3'b000;
      sound_stb_q <= 1'b0;
      sound_id_q  <= 2'b00;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so the memory write and the slot read in
      // always_comb see the pre-edge contents in the same cycle.
      if (bus.prog_we) mem_q[bus.prog_addr] <= bus.prog_data;
      state_q     <= state_d;
      step_q      <= step_d;
      dwell_cnt_q <= dwell_cnt_d;
      opcode_q    <= opcode_d;
      color_q     <= color_d;
      effect_q    <= effect_d;
      sound_stb_q <= sound_stb_d;
      sound_id_q  <= sound_id_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
    end
  end

  assign bus.opcode    = opcode_q;
  assign bus.step      = step_q;
  assign bus.running   = (state_q == S_RUN);
  assign bus.color     = color_q;
  assign bus.sound_stb = sound_stb_q;
  assign bus.sound_id  = sound_id_q;
  assign bus.effect    = effect_q;
  assign bus.wrap      = wrap_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_decoration_sequencer.sv
// Directed self-checking bench for decoration_sequencer (NUM_CH = 4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_decoration_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   stb_count;
  int   step3_count;

  decoration_sequencer_if #(.NUM_CH(4), .DWELL_W(8)) bus ();

  decoration_sequencer #(.NUM_CH(4), .DWELL_W(8), .OP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic write_slot(input logic [1:0] addr, input logic [3:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = data;
    tick(1);
    bus.prog_we   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.on = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0;
    bus.prog_data = '0; bus.dwell = '0;
    tick(2);
    do_reset();
    check("rst_running", bus.running, 0);
    check("rst_opcode", bus.opcode, 0);
    check("rst_step", bus.step, 0);
    check("rst_color", bus.color, 0);
    check("rst_effect", bus.effect, 0);
    check("rst_err", bus.err, 0);
    check("rst_wrap", bus.wrap, 0);

    // 1: {GREEN, CACKLING, FOG, PURPLE}, dwell 2 -> steps 3 cycles apart.
    write_slot(0, 4'b0100); write_slot(1, 4'b1001);
    write_slot(2, 4'b1110); write_slot(3, 4'b0101);
    bus.dwell = 8'd2; bus.on = 1'b1;
    tick(1);                                   // cycle 0
    check("t1_c0_running", bus.running, 1);
    check("t1_c0_opcode", bus.opcode, 4'b0100);
    check("t1_c0_color", bus.color, 2'b01);
    check("t1_c0_wrap", bus.wrap, 0);
    tick(2);                                   // cycle 2
    check("t1_c2_step", bus.step, 0);
    tick(1);                                   // cycle 3
    check("t1_c3_step", bus.step, 1);
    check("t1_c3_stb", bus.sound_stb, 1);
    check("t1_c3_sid", bus.sound_id, 2'b01);
    check("t1_c3_color", bus.color, 2'b01);
    tick(1);                                   // cycle 4
    check("t1_c4_stb", bus.sound_stb, 0);
    tick(1);                                   // cycle 5
    check("t1_c5_effect", bus.effect, 3'b000);
    tick(1);                                   // cycle 6
    check("t1_c6_step", bus.step, 2);
    check("t1_c6_effect", bus.effect, 3'b100);
    tick(2);                                   // cycle 8
    check("t1_c8_effect", bus.effect, 3'b100);
    tick(1);                                   // cycle 9
    check("t1_c9_step", bus.step, 3);
    check("t1_c9_effect", bus.effect, 3'b000);
    check("t1_c9_color", bus.color, 2'b10);
    tick(2);                                   // cycle 11
    check("t1_c11_wrap", bus.wrap, 0);
    tick(1);                                   // cycle 12
    check("t1_c12_step", bus.step, 0);
    check("t1_c12_wrap", bus.wrap, 1);
    check("t1_c12_color", bus.color, 2'b01);
    tick(1);                                   // cycle 13
    check("t1_c13_wrap", bus.wrap, 0);
    bus.on = 1'b0;
    tick(1);
    check("t1_off_running", bus.running, 0);

    // 2: empty program never starts; a write to slot 0 starts it next cycle.
    do_reset();
    bus.on = 1'b1;
    tick(2);
    check("t2_empty_idle", bus.running, 0);
    write_slot(0, 4'b1100);
    check("t2_write_edge_idle", bus.running, 0);
    tick(1);
    check("t2_run", bus.running, 1);
    check("t2_effect", bus.effect, 3'b001);
    check("t2_opcode", bus.opcode, 4'b1100);
    bus.on = 1'b0;
    tick(1);

    // 3: {ORANGE, MOVEJAW, RESET, SCREAMING}, dwell 4.
    do_reset();
    write_slot(0, 4'b0110); write_slot(1, 4'b1101);
    write_slot(2, 4'b0001); write_slot(3, 4'b1000);
    bus.dwell = 8'd4; bus.on = 1'b1;
    tick(1);                                   // cycle 0
    check("t3_c0_color", bus.color, 2'b11);
    tick(5);                                   // cycle 5
    check("t3_c5_step", bus.step, 1);
    check("t3_c5_effect", bus.effect, 3'b010);
    tick(5);                                   // cycle 10
    check("t3_c10_step", bus.step, 2);
    check("t3_c10_opcode", bus.opcode, 4'b0001);
    check("t3_c10_color", bus.color, 2'b00);
    check("t3_c10_effect", bus.effect, 3'b000);
    tick(1);                                   // cycle 11
    check("t3_c11_step", bus.step, 0);
    check("t3_c11_wrap", bus.wrap, 0);
    check("t3_c11_color", bus.color, 2'b11);
    stb_count = 0; step3_count = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.sound_stb) stb_count++;
      if (bus.step == 2'd3) step3_count++;
      tick(1);
    end
    check("t3_no_stb", stb_count, 0);
    check("t3_no_step3", step3_count, 0);
    bus.on = 1'b0;
    tick(1);

    // 4: reserved opcode in slot 1 sets a sticky err.
    do_reset();
    write_slot(0, 4'b0100); write_slot(1, 4'b0111);
    bus.dwell = 8'd0; bus.on = 1'b1;
    tick(1);
    check("t4_c0_err", bus.err, 0);
    tick(1);
    check("t4_c1_step", bus.step, 1);
    check("t4_c1_err", bus.err, 1);
    check("t4_c1_color", bus.color, 2'b01);
    bus.on = 1'b0;
    tick(3);
    check("t4_off_err", bus.err, 1);
    do_reset();
    check("t4_rst_err", bus.err, 0);

    // 5: drop on mid-dwell of step 2, then rst during RUN.
    write_slot(0, 4'b0100); write_slot(1, 4'b0101); write_slot(2, 4'b0110);
    bus.dwell = 8'd3; bus.on = 1'b1;
    tick(1);                                   // cycle 0
    tick(8);                                   // cycle 8
    check("t5_c8_step", bus.step, 2);
    check("t5_c8_color", bus.color, 2'b11);
    tick(1);                                   // cycle 9, mid-dwell
    bus.on = 1'b0;
    tick(1);
    check("t5_off_running", bus.running, 0);
    check("t5_off_opcode", bus.opcode, 0);
    check("t5_off_color", bus.color, 0);
    check("t5_off_step", bus.step, 0);
    bus.on = 1'b1;
    tick(3);
    check("t5_rerun", bus.running, 1);
    do_reset();
    check("t5_rst_running", bus.running, 0);
    check("t5_rst_color", bus.color, 0);
    check("t5_rst_opcode", bus.opcode, 0);
    tick(2);
    check("t5_mem_slot0_clear", bus.running, 0);
    write_slot(0, 4'b0100);
    tick(1);
    check("t5_restart", bus.running, 1);
    tick(4);
    check("t5_slot1_step", bus.step, 1);
    check("t5_mem_slot1_clear", bus.opcode, 0);
    tick(4);
    check("t5_mem_slot2_clear", bus.opcode, 0);
    check("t5_color_hold", bus.color, 2'b01);
    bus.on = 1'b0;
    tick(1);

`ifdef SEQ_ONESHOT_EN
    // 6: one-shot playback of four colour steps with dwell 0.
    do_reset();
    write_slot(0, 4'b0100); write_slot(1, 4'b0101);
    write_slot(2, 4'b0110); write_slot(3, 4'b0101);
    bus.dwell = 8'd0; bus.on = 1'b1;
    tick(1);
    check("t6_c0_step", bus.step, 0);
    tick(3);
    check("t6_c3_step", bus.step, 3);
    check("t6_c3_color", bus.color, 2'b10);
    tick(1);
    check("t6_done_running", bus.running, 0);
    check("t6_done_wrap", bus.wrap, 0);
    check("t6_done_opcode", bus.opcode, 0);
    check("t6_done_color", bus.color, 2'b10);
    tick(2);
    check("t6_done_hold", bus.running, 0);
    bus.on = 1'b0;
    tick(1);
    bus.on = 1'b1;
    tick(1);
    check("t6_restart_running", bus.running, 1);
    check("t6_restart_step", bus.step, 0);
    check("t6_restart_color", bus.color, 2'b01);
    bus.on = 1'b0;
    tick(1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
